// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE X input staging buffer.
// Holds the element-format enum and width helper, the buffer control and flag
// payloads, and the per-bank state encoding.
package redmule_pkg;

   // Floating-point element formats understood by the datapath.
   typedef enum logic [2:0] {
      FP32    = 3'd0,
      FP64    = 3'd1,
      FP16    = 3'd2,
      FP8     = 3'd3,
      FP16ALT = 3'd4
   } fp_format_e;

   // Bit width of one element of the given format.
   function automatic int unsigned fp_width(input fp_format_e fmt);
      case (fmt)
         FP64:          return 64;
         FP32:          return 32;
         FP16, FP16ALT: return 16;
         default:       return 8;
      endcase
   endfunction

   localparam int unsigned ARRAY_HEIGHT = 4;
   localparam int unsigned X_CTRL_W     = 8;

   // Valid region of a bank: x_height rows (1..H), x_width columns (1..D).
   typedef struct packed {
      logic [X_CTRL_W-1:0] x_height;
      logic [X_CTRL_W-1:0] x_width;
   } x_buffer_ctrl_t;

   typedef struct packed {
      logic full;
      logic empty;
      logic bank_done;
   } x_buffer_flgs_t;

   typedef enum logic [1:0] {
      X_EMPTY    = 2'd0,
      X_FILLING  = 2'd1,
      X_FULL     = 2'd2,
      X_DRAINING = 2'd3
   } x_bank_state_e;

endpackage

// File: rtl/redmule_x_buffer_bank.sv
// One H x D storage bank of the X buffer: row-wide write port, transposed
// column read port with zero padding for rows at or beyond the valid height.
// Ports:
//   i_clk     clock (storage is not reset)
//   i_we      write enable for row i_wr_row
//   i_wr_row  row written by i_word
//   i_word    full-width streamer word
//   i_rd_col  column selected for reading
//   i_height  number of valid rows; higher rows read as zero
//   o_col_c   combinational column, one element per row
module redmule_x_buffer_bank
   import redmule_pkg::*;
#(
   parameter int unsigned DW   = 288,
   parameter int unsigned BITW = 16,
   parameter int unsigned H    = ARRAY_HEIGHT
) (
   input  logic                        i_clk,
   input  logic                        i_we,
   input  logic [((H > 1) ? $clog2(H) : 1)-1:0] i_wr_row,
   input  logic [DW-1:0]               i_word,
   input  logic [(((DW/BITW) > 1) ? $clog2(DW/BITW) : 1)-1:0] i_rd_col,
   input  logic [X_CTRL_W-1:0]         i_height,
   output logic [H-1:0][BITW-1:0]      o_col_c
);

   localparam int unsigned D = DW / BITW;

   logic [D-1:0][BITW-1:0] r_mem [H];

   // Row write; contents deliberately carry no reset.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_wr_row] <= i_word[D*BITW-1:0];
   end

   // Column read with zero padding above the valid height.
   always_comb begin
      o_col_c = '0;
      for (int unsigned r = 0; r < H; r++) begin
         if (X_CTRL_W'(r) < i_height) o_col_c[r] = r_mem[r][i_rd_col];
      end
   end

endmodule

// File: rtl/redmule_x_pingpong_buffer.sv
// RedMulE X input staging buffer. Streamer words are written as rows; the
// engine reads one transposed column per request with one cycle of latency.
// Macro REDMULE_X_BUF_DOUBLE_EN selects two ping-pong banks; without it a
// single bank is used and writes stall until the bank is fully drained.
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync soft clear)
//   ctrl_i        valid height/width of a bank
//   word_i / word_valid_i / word_ready_o   streamer write handshake
//   col_req_i / col_avail_o                engine column request
//   col_o / col_valid_o                    registered column result
//   flags_o       full, empty, bank_done (bank_done is same-cycle)
module redmule_x_pingpong_buffer
   import redmule_pkg::*;
#(
   parameter int unsigned DW       = 288,
   parameter fp_format_e  FpFormat = FP16,
   parameter int unsigned Height   = ARRAY_HEIGHT
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     clear_i,
   input  x_buffer_ctrl_t                           ctrl_i,
   input  logic [DW-1:0]                            word_i,
   input  logic                                     word_valid_i,
   output logic                                     word_ready_o,
   input  logic                                     col_req_i,
   output logic                                     col_avail_o,
   output logic [Height-1:0][fp_width(FpFormat)-1:0] col_o,
   output logic                                     col_valid_o,
   output x_buffer_flgs_t                           flags_o
);

   localparam int unsigned BITW = fp_width(FpFormat);
   localparam int unsigned D    = DW / BITW;
   localparam int unsigned RW   = (Height > 1) ? $clog2(Height) : 1;
   localparam int unsigned CW   = (D > 1) ? $clog2(D) : 1;
`ifdef REDMULE_X_BUF_DOUBLE_EN
   localparam int unsigned NB   = 2;
`else
   localparam int unsigned NB   = 1;
`endif

   typedef logic [Height-1:0][BITW-1:0] col_t;

   x_bank_state_e r_state [NB];
   logic [RW-1:0] r_wr_row;
   logic [CW-1:0] r_rd_col;
   col_t          r_col;
   logic          r_col_valid;
   logic          w_wr_bank, w_rd_bank;
   x_bank_state_e w_wr_st, w_rd_st;
   col_t          w_bank_col [NB];
   col_t          w_rd_data;
   logic          w_wr_fire, w_rd_fire, w_wr_last, w_rd_last;

`ifdef REDMULE_X_BUF_DOUBLE_EN
   logic r_wr_bank, r_rd_bank;
   assign w_wr_bank = r_wr_bank;
   assign w_rd_bank = r_rd_bank;
`else
   assign w_wr_bank = 1'b0;
   assign w_rd_bank = 1'b0;
`endif

   // Pick the state and column of the banks the pointers address.
   always_comb begin
      w_wr_st   = r_state[0];
      w_rd_st   = r_state[0];
      w_rd_data = w_bank_col[0];
      for (int unsigned b = 1; b < NB; b++) begin
         if (w_wr_bank == 1'(b)) w_wr_st = r_state[b];
         if (w_rd_bank == 1'(b)) begin
            w_rd_st   = r_state[b];
            w_rd_data = w_bank_col[b];
         end
      end
   end

   assign word_ready_o = (w_wr_st == X_EMPTY) || (w_wr_st == X_FILLING);
   assign col_avail_o  = (w_rd_st == X_FULL)  || (w_rd_st == X_DRAINING);

   assign w_wr_fire = word_valid_i && word_ready_o && !clear_i;
   assign w_rd_fire = col_req_i && col_avail_o && !clear_i;
   assign w_wr_last = (X_CTRL_W'(r_wr_row) == ctrl_i.x_height - X_CTRL_W'(1));
   assign w_rd_last = (X_CTRL_W'(r_rd_col) == ctrl_i.x_width  - X_CTRL_W'(1));

   for (genvar b = 0; b < NB; b++) begin : g_bank
      redmule_x_buffer_bank #(
         .DW   (DW),
         .BITW (BITW),
         .H    (Height)
      ) u_bank (
         .i_clk    (clk_i),
         .i_we     (w_wr_fire && (w_wr_bank == 1'(b))),
         .i_wr_row (r_wr_row),
         .i_word   (word_i),
         .i_rd_col (r_rd_col),
         .i_height (ctrl_i.x_height),
         .o_col_c  (w_bank_col[b])
      );
   end

   // Aggregate flags; bank_done marks the cycle of the final column request.
   always_comb begin
      flags_o           = '0;
      flags_o.full      = 1'b1;
      flags_o.empty     = 1'b1;
      for (int unsigned b = 0; b < NB; b++) begin
         if (!((r_state[b] == X_FULL) || (r_state[b] == X_DRAINING))) flags_o.full = 1'b0;
         if (r_state[b] != X_EMPTY) flags_o.empty = 1'b0;
      end
      flags_o.bank_done = w_rd_fire && w_rd_last;
   end

   assign col_o       = r_col;
   assign col_valid_o = r_col_valid;

   // Bank state machines, pointers and registered read result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned b = 0; b < NB; b++) r_state[b] <= X_EMPTY;
         r_wr_row    <= '0;
         r_rd_col    <= '0;
         r_col       <= '0;
         r_col_valid <= 1'b0;
`ifdef REDMULE_X_BUF_DOUBLE_EN
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
`endif
      end else if (clear_i) begin
         // Soft clear drops the in-flight result but keeps the last col_o.
         for (int unsigned b = 0; b < NB; b++) r_state[b] <= X_EMPTY;
         r_wr_row    <= '0;
         r_rd_col    <= '0;
         r_col_valid <= 1'b0;
`ifdef REDMULE_X_BUF_DOUBLE_EN
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
`endif
      end else begin
         r_col_valid <= w_rd_fire;
         if (w_rd_fire) begin
            r_col    <= w_rd_data;
            r_rd_col <= w_rd_last ? '0 : r_rd_col + CW'(1);
         end
         if (w_wr_fire) r_wr_row <= w_wr_last ? '0 : r_wr_row + RW'(1);
         // A bank is never both writable and readable, so the two never collide.
         for (int unsigned b = 0; b < NB; b++) begin
            if (w_wr_fire && (w_wr_bank == 1'(b)))
               r_state[b] <= w_wr_last ? X_FULL : X_FILLING;
            else if (w_rd_fire && (w_rd_bank == 1'(b)))
               r_state[b] <= w_rd_last ? X_EMPTY : X_DRAINING;
         end
`ifdef REDMULE_X_BUF_DOUBLE_EN
         if (w_wr_fire && w_wr_last) r_wr_bank <= ~r_wr_bank;
         if (w_rd_fire && w_rd_last) r_rd_bank <= ~r_rd_bank;
`endif
      end
   end

endmodule

// File: tb/tb_redmule_x_pingpong_buffer.sv
// Self-checking bench for redmule_x_pingpong_buffer: directed scenarios plus
// randomized traffic compared cycle by cycle against a bank-occupancy model.
module tb_redmule_x_pingpong_buffer;
   import redmule_pkg::*;

   localparam int unsigned DW = 288;
   localparam int unsigned BW = 16;
   localparam int unsigned H  = 4;
   localparam int unsigned D  = DW / BW;
`ifdef REDMULE_X_BUF_DOUBLE_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   logic                clk, rst, clear;
   x_buffer_ctrl_t      ctrl;
   logic [DW-1:0]       word;
   logic                word_valid, word_ready;
   logic                col_req, col_avail, col_valid;
   logic [H-1:0][BW-1:0] col;
   x_buffer_flgs_t      flags;

   redmule_x_pingpong_buffer #(
      .DW(DW), .FpFormat(FP16), .Height(H)
   ) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .ctrl_i(ctrl),
      .word_i(word), .word_valid_i(word_valid), .word_ready_o(word_ready),
      .col_req_i(col_req), .col_avail_o(col_avail), .col_o(col),
      .col_valid_o(col_valid), .flags_o(flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: each bank is a list of stored rows plus a read count.
   logic [DW-1:0] m_mem [2][H];
   int            m_cnt_w [2];
   int            m_cnt_r [2];
   bit            m_full  [2];
   int            m_wb, m_rb;
   logic [63:0]   m_col;
   bit            m_cv;
   int            xh, xw;

   task automatic model_clear();
      for (int b = 0; b < 2; b++) begin
         m_cnt_w[b] = 0; m_cnt_r[b] = 0; m_full[b] = 0;
      end
      m_wb = 0; m_rb = 0; m_cv = 0;
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // One clock cycle: drive, check combinational outputs, clock, check results.
   task automatic step(input bit wv, input logic [DW-1:0] w, input bit req, input bit clr);
      bit acc, fire, e_full, e_empty, e_done;
      @(negedge clk);
      word_valid = wv; word = w; col_req = req; clear = clr;
      ctrl.x_height = 8'(xh); ctrl.x_width = 8'(xw);
      #4;
      acc  = wv && !m_full[m_wb] && !clr;
      fire = req && m_full[m_rb] && !clr;
      e_done = fire && (m_cnt_r[m_rb] == xw - 1);
      e_full = 1; e_empty = 1;
      for (int b = 0; b < NB; b++) begin
         e_full  = e_full && m_full[b];
         e_empty = e_empty && !m_full[b] && (m_cnt_w[b] == 0);
      end
      check("word_ready", 64'(word_ready), 64'(!m_full[m_wb]));
      check("col_avail",  64'(col_avail),  64'(m_full[m_rb]));
      check("flag_full",  64'(flags.full),  64'(e_full));
      check("flag_empty", 64'(flags.empty), 64'(e_empty));
      check("bank_done",  64'(flags.bank_done), 64'(e_done));
      @(posedge clk); #1;
      if (clr) begin
         model_clear();
      end else begin
         m_cv = fire;
         if (fire) begin
            for (int r = 0; r < H; r++)
               m_col[r*BW +: BW] = (r < xh) ? m_mem[m_rb][r][m_cnt_r[m_rb]*BW +: BW] : 16'h0;
            m_cnt_r[m_rb]++;
            if (m_cnt_r[m_rb] == xw) begin
               m_cnt_r[m_rb] = 0; m_full[m_rb] = 0; m_cnt_w[m_rb] = 0;
               if (NB == 2) m_rb ^= 1;
            end
         end
         if (acc) begin
            m_mem[m_wb][m_cnt_w[m_wb]] = w;
            m_cnt_w[m_wb]++;
            if (m_cnt_w[m_wb] == xh) begin
               m_full[m_wb] = 1; m_cnt_w[m_wb] = 0;
               if (NB == 2) m_wb ^= 1;
            end
         end
      end
      check("col_valid", 64'(col_valid), 64'(m_cv));
      check("col_o", col, m_col);
   endtask

   task automatic do_clear(input int h, input int wd);
      xh = h; xw = wd;
      step(0, '0, 0, 1);
   endtask

   initial begin
      rst = 1; clear = 0; word_valid = 0; word = '0; col_req = 0;
      xh = 4; xw = 18; ctrl.x_height = 8'd4; ctrl.x_width = 8'd18;
      model_clear(); m_col = '0;
      #12;
      check("rst_word_ready", 64'(word_ready), 64'd1);
      check("rst_col_avail",  64'(col_avail),  64'd0);
      check("rst_col_valid",  64'(col_valid),  64'd0);
      check("rst_col_o",      col,             64'd0);
      check("rst_flags",      64'(flags),      64'b010);
      @(negedge clk); rst = 0;

      // Fill and drain: rows hold 1..4 so every column reads {4,3,2,1}.
      for (int i = 0; i < 4; i++) step(1, {18{16'(i + 1)}}, 0, 0);
      for (int i = 0; i < 18; i++) begin
         step(0, '0, 1, 0);
         check("col_4321", col, 64'h0004_0003_0002_0001);
      end
      step(0, '0, 0, 0);

      // Ping-pong: back-to-back words, stall, then drain alongside writes.
      do_clear(4, 4);
      for (int i = 0; i < 12; i++) step(1, rand_word(), 0, 0);
      for (int i = 0; i < 12; i++) step(1, rand_word(), 1, 0);
      for (int i = 0; i < 6; i++) step(0, '0, 1, 0);

      // Padding and partial width.
      do_clear(2, 3);
      for (int i = 0; i < 2; i++) step(1, rand_word(), 0, 0);
      for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

      // Requests with no full bank are ignored.
      do_clear(3, 2);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, rand_word(), 0, 0);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0);

      // Clear mid-fill, then a clean fill/drain.
      do_clear(4, 5);
      for (int i = 0; i < 2; i++) step(1, rand_word(), 0, 0);
      step(1, rand_word(), 1, 1);
      for (int i = 0; i < 4; i++) step(1, rand_word(), 0, 0);
      for (int i = 0; i < 6; i++) step(0, '0, 1, 0);

      // Clear mid-drain with a request in the same cycle.
      for (int i = 0; i < 4; i++) step(1, rand_word(), 0, 0);
      for (int i = 0; i < 2; i++) step(0, '0, 1, 0);
      step(0, '0, 1, 1);
      for (int i = 0; i < 4; i++) step(1, rand_word(), 0, 0);
      for (int i = 0; i < 6; i++) step(0, '0, 1, 0);

      // Asynchronous reset mid-drain takes effect before the next edge.
      for (int i = 0; i < 4; i++) step(1, rand_word(), 0, 0);
      step(0, '0, 1, 0);
      @(negedge clk);
      col_req = 1; word_valid = 0;
      #2 rst = 1;
      #1;
      check("arst_col_o",      col,              64'd0);
      check("arst_col_valid",  64'(col_valid),   64'd0);
      check("arst_empty",      64'(flags.empty), 64'd1);
      check("arst_word_ready", 64'(word_ready),  64'd1);
      check("arst_col_avail",  64'(col_avail),   64'd0);
      @(negedge clk); rst = 0; col_req = 0;
      model_clear(); m_col = '0;

      // Randomized traffic across geometries, including x_height/x_width of 1.
      for (int rnd = 0; rnd < 10; rnd++) begin
         case (rnd)
            0: do_clear(1, 1);
            1: do_clear(1, 18);
            2: do_clear(4, 1);
            3: do_clear(4, 18);
            default: do_clear(int'($urandom_range(1, H)), int'($urandom_range(1, D)));
         endcase
         for (int c = 0; c < 150; c++)
            step(($urandom % 4) != 0, rand_word(), ($urandom % 3) == 0, ($urandom % 60) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/redmule_x_pingpong_buffer.md
# redmule_x_pingpong_buffer

Input-side staging buffer for the RedMulE datapath, and the counterpart of the Z output buffer. It accepts full-width X words from the streamer over a valid/ready handshake and stores them as rows. It then hands the engine one transposed column per request: one element from each stored row. Two banks operate in ping-pong so the streamer can refill one bank while the engine drains the other.

## Interface
- DW, 288: streamer word width in bits.
- FpFormat, fpnew_pkg::FP16: element format; BITW = fp_width(FpFormat).
- Height, ARRAY_HEIGHT: rows per bank (H); elements per output column.
- localparam D = DW/BITW: elements per word (columns per bank).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous soft clear.
- ctrl_i  in  x_buffer_ctrl_t  fields: x_height (1..H valid rows), x_width (1..D valid columns).
- word_i  in  DW  streamer word, written as one row.
- word_valid_i  in  1  streamer word valid.
- word_ready_o  out  1  buffer accepts word.
- col_req_i  in  1  engine requests next column.
- col_avail_o  out  1  a full bank is readable.
- col_o  out  [H-1:0][BITW-1:0]  column data.
- col_valid_o  out  1  col_o valid.
- flags_o  out  x_buffer_flgs_t  fields: full, empty, bank_done.

## Operation
- Each bank has a two-bit state: EMPTY, FILLING, FULL, DRAINING.
- A write pointer wr_bank and a read pointer rd_bank alternate between bank 0 and bank 1.
- Write acceptance: a word is accepted when word_valid_i && word_ready_o.
- word_ready_o = state[wr_bank] ∈ {EMPTY, FILLING}.
- An accepted word is stored in row wr_row of bank wr_bank; wr_row then increments.
- The first accepted word moves the bank EMPTY→FILLING.
- The word with wr_row == x_height-1 moves the bank →FULL (directly from EMPTY when x_height = 1), resets wr_row to 0 and toggles wr_bank.
- col_avail_o = state[rd_bank] ∈ {FULL, DRAINING}.
- col_req_i while col_avail_o reads column rd_col of bank rd_bank:
  - rows < x_height deliver the stored element;
  - rows ≥ x_height deliver 0.
- The first request moves the bank FULL→DRAINING.
- The request with rd_col == x_width-1 moves the bank →EMPTY (directly from FULL when x_width = 1), resets rd_col, toggles rd_bank, and pulses flags_o.bank_done for that cycle.
- col_req_i while col_avail_o is low is ignored: no pointer change, col_valid_o stays low.
- flags_o.full = both banks FULL/DRAINING. flags_o.empty = both banks EMPTY.
- ctrl_i must be stable between clear_i pulses. x_height = 0 or x_width = 0 is illegal.
- Counter widths:
  - wr_row: $clog2(H) bits; wraps only at x_height-1, never by overflow.
  - rd_col: $clog2(D) bits; wraps only at x_width-1, never by overflow.

## Timing
- Reset values:
  - all banks EMPTY; pointers and counters 0;
  - word_ready_o = 1; col_avail_o = 0; col_valid_o = 0; col_o = 0; flags_o.full = 0, flags_o.bank_done = 0, flags_o.empty = 1.
- Storage contents are not reset.
- word_ready_o and col_avail_o are combinational from registered state only, with no path from valid or request inputs.
- Read latency is 1 cycle: col_o and col_valid_o are registered. col_valid_o is high exactly one cycle after each accepted request.
- A bank completed by a write becomes readable (col_avail_o) in the next cycle.
- A bank freed by the last read becomes writable in the next cycle.
- Simultaneous write into one bank and read of the other bank are both performed.
- clear_i has priority over every event in the same cycle:
  - all banks EMPTY, pointers and counters 0;
  - col_valid_o = 0 on the next cycle;
  - the in-flight read result is dropped.
- rst_i asserted mid-operation takes effect immediately (asynchronous), with the same end state as clear_i plus col_o = 0.

## Configuration
- REDMULE_X_BUF_DOUBLE_EN defined:
  - two banks, ping-pong operation as above.
- Not defined:
  - single bank; wr_bank and rd_bank are tied to 0;
  - writes stall (word_ready_o = 0) from FULL until the bank returns to EMPTY;
  - reads are unavailable until FULL;
  - flags_o.full = bank FULL/DRAINING.

## Structure
- redmule_pkg holds:
  - x_buffer_ctrl_t and x_buffer_flgs_t;
  - the bank state enum (x_bank_state_e).
- Sub-module redmule_x_buffer_bank: an H×D latch/flop array with a row-write port (DW) and a column-read port (H×BITW), including zero-padding for rows ≥ x_height. It is instantiated once or twice depending on REDMULE_X_BUF_DOUBLE_EN.

## Test plan
- Fill and drain, H=4, D=18, x_height=4, x_width=18:
  - Stimulus: 4 words with word i having all elements = i+1.
  - Response: the 4th word raises col_avail_o next cycle; 18 requests each return col_o = {4,3,2,1} one cycle later; bank_done pulses on request 18.
- Ping-pong (DOUBLE_EN):
  - Stimulus: stream 8 words back-to-back.
  - Response: word_ready_o stays 1 for all 8; flags_o.full = 1 after word 8; word_ready_o drops until bank 0 is drained.
- Padding and partial width, x_height=2, x_width=3:
  - Response: 2 words fill the bank; col_o rows 2–3 = 0; the bank returns to EMPTY after exactly 3 requests.
- Request with no full bank:
  - Stimulus: col_req_i pulsed while col_avail_o = 0.
  - Response: col_valid_o stays 0; rd_col is unchanged.
- Clear mid-fill and mid-drain:
  - Stimulus: clear_i after 2 writes and during a request.
  - Response: next cycle col_valid_o = 0, flags_o.empty = 1, word_ready_o = 1; the next full fill behaves as from reset.
- Single-bank build (macro undefined):
  - Response: word_ready_o = 0 from the fill cycle until the last column request, then 1 on the following cycle.
